// File: rtl/arm_mc_pkg.sv
// Shared encodings for the ARMv4-subset multicycle controller: FSM states,
// ALU operation codes, condition codes and datapath mux selects.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Data-processing command decode; arith marks the ops that own C and V.
  typedef struct packed {
    alu_ctl_t ctl;
    logic     valid;
    logic     nowrite;
    logic     arith;
  } dp_dec_t;

  function automatic dp_dec_t decode_dp(input logic [3:0] cmd);
    dp_dec_t d;
    d = '{ctl: ALU_ADD, valid: 1'b0, nowrite: 1'b0, arith: 1'b0};
    case (cmd)
      4'b0100: d = '{ctl: ALU_ADD, valid: 1'b1, nowrite: 1'b0, arith: 1'b1};
      4'b0010: d = '{ctl: ALU_SUB, valid: 1'b1, nowrite: 1'b0, arith: 1'b1};
      4'b0000: d = '{ctl: ALU_AND, valid: 1'b1, nowrite: 1'b0, arith: 1'b0};
      4'b1100: d = '{ctl: ALU_ORR, valid: 1'b1, nowrite: 1'b0, arith: 1'b0};
      4'b1010: d = '{ctl: ALU_SUB, valid: 1'b1, nowrite: 1'b1, arith: 1'b1};
      4'b1000: d = '{ctl: ALU_AND, valid: 1'b1, nowrite: 1'b1, arith: 1'b0};
      default: d = '{ctl: ALU_ADD, valid: 1'b0, nowrite: 1'b0, arith: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_mc_condcheck.sv
// Combinational ARM condition evaluation: 4-bit cond field against the
// registered {N,Z,C,V} flags.
module arm_mc_condcheck
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_t'(cond_i))
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = ~(n ^ v);
      COND_LT: cond_ex_o = n ^ v;
      COND_GT: cond_ex_o = ~z & ~(n ^ v);
      COND_LE: cond_ex_o = z | (n ^ v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARMv4-subset control unit: instruction FSM with mem_ready wait
// states, NZCV flag register and condition gating of all architectural writes.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic        reg_write,
  output logic [3:0]  flags,
  output logic [3:0]  state_o
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign funct     = instr[13:8];
  assign rd        = instr[3:0];
  assign unused_rn = ^instr[7:4];

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  dp_dec_t    dp;
  alu_ctl_t   alu_ctl;
  logic       pc_en, ir_en, mem_en, reg_en;

  assign dp = decode_dp(funct[4:1]);

  arm_mc_condcheck u_condcheck (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_en     = 1'b0;
    reg_en     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_ctl    = ALU_ADD;
    result_src = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // PC+4 computed again here so R15 reads as PC+8.
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (op)
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        if (rd == 4'd15) pc_en  = cond_ex;
        else             reg_en = cond_ex;
        state_d = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_en  = cond_ex;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        alu_src_b = (state_q == EXECUTEI) ? SRCB_IMM : SRCB_REG;
        alu_ctl   = dp.ctl;
        if (dp.valid) begin
          state_d = ALUWB;
          // Logical ops leave C and V alone.
          if (funct[0] && cond_ex) begin
            flags_d[3:2] = alu_flags[3:2];
            if (dp.arith) flags_d[1:0] = alu_flags[1:0];
          end
        end else begin
          state_d = FETCH;
        end
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        if (cond_ex && !dp.nowrite) begin
          if (rd == 4'd15) pc_en  = 1'b1;
          else             reg_en = 1'b1;
        end
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_en      = cond_ex;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables are forced low for the whole time reset is high.
  assign pc_write    = pc_en  & ~reset;
  assign ir_write    = ir_en  & ~reset;
  assign mem_write   = mem_en & ~reset;
  assign reg_write   = reg_en & ~reset;
  assign alu_control = alu_ctl;
  assign imm_src     = op;
  assign reg_src     = {op == 2'b01, op == 2'b10};
  assign flags       = flags_q;
  assign state_o     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

endmodule
